// File: rtl/pong_game_core_if.sv
// pong_game_core_if: paddle inputs, start request and ball/score/status outputs of the pong engine
interface pong_game_core_if #(
  parameter int NUM_PADDLES = 2,
  parameter int SCORE_W = 8
);
  logic START;
  logic [10*NUM_PADDLES-1:0] PADDLE_X;
  logic [9:0] BALL_X;
  logic [9:0] BALL_Y;
  logic [SCORE_W-1:0] SCORE;
  logic [3:0] LIVES_LEFT;
  logic [1:0] STATE;
  logic HIT_PULSE;
  logic MISS_PULSE;
  modport master (output START, PADDLE_X, input BALL_X, BALL_Y, SCORE, LIVES_LEFT, STATE, HIT_PULSE, MISS_PULSE);
  modport slave (input START, PADDLE_X, output BALL_X, BALL_Y, SCORE, LIVES_LEFT, STATE, HIT_PULSE, MISS_PULSE);
endinterface

// File: rtl/pong_game_core.sv
// pong_game_core: ball motion, wall/paddle collisions, score, lives and serve/play/over control
module pong_game_core #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BORDER = 5,
  parameter int BALL_SIZE = 15,
  parameter int PADDLE_W = 80,
  parameter int PADDLE_Y = 450,
  parameter int NUM_PADDLES = 2,
  parameter int LIVES = 3,
  parameter int SERVE_TICKS = 64,
  parameter int BASE_DIV = 80000,
  parameter int DIV_STEP = 500,
  parameter int MIN_DIV = 20000,
  parameter int SCORE_W = 8
) (
  input logic CLK_50,
  input logic RESET,
  pong_game_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  localparam logic [9:0] CX = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] CY = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] BS = 11'(BALL_SIZE);
  localparam logic [10:0] BR = 11'(BORDER);
  localparam logic [10:0] RW = 11'(SCREEN_W - BORDER);
  localparam logic [10:0] SH = 11'(SCREEN_H);
  localparam logic [10:0] PY = 11'(PADDLE_Y);
  localparam logic [10:0] PW = 11'(PADDLE_W);
  localparam logic [31:0] BD = 32'(BASE_DIV);
  localparam logic [31:0] DS = 32'(DIV_STEP);
  localparam logic [31:0] MD = 32'(MIN_DIV);
  localparam logic [15:0] ST = 16'(SERVE_TICKS);
  localparam logic [3:0] LV = 4'(LIVES);
  state_t state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic dx_q, dx_d, dy_q, dy_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0] lives_q, lives_d;
  logic [31:0] cnt_q, cnt_d, prod, div;
  logic [15:0] serve_q, serve_d;
  logic hit_q, hit_d, miss_q, miss_d, start_q;
  logic [10:0] xe, ye;
  logic run, tick, rise, miss, over, phit, dx_n, dy_n;
  always_comb begin
    over = 1'b0;
    for (int i = 0; i < NUM_PADDLES; i++)
      over = over | (({1'b0, x_q} + BS > {1'b0, bus.PADDLE_X[10*i +: 10]}) && ({1'b0, x_q} < {1'b0, bus.PADDLE_X[10*i +: 10]} + PW));
  end
  always_comb begin
    xe = {1'b0, x_q};
    ye = {1'b0, y_q};
    prod = DS * 32'(score_q);
    div = prod > BD - MD ? MD : BD - prod;
    run = state_q == SERVE || state_q == PLAY;
    tick = run && cnt_q >= div - 32'd1;
    rise = bus.START && !start_q;
    miss = ye + BS >= SH;
    phit = dy_q && ye + BS == PY && over;
    dx_n = xe <= BR ? 1'b1 : xe + BS >= RW ? 1'b0 : dx_q;
    dy_n = ye <= BR ? 1'b1 : phit ? 1'b0 : dy_q;
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    score_d = score_q;
    lives_d = lives_q;
    serve_d = serve_q;
    cnt_d = tick || !run ? 32'd0 : cnt_q + 32'd1;
    hit_d = 1'b0;
    miss_d = 1'b0;
    case (state_q)
      IDLE: state_d = rise ? SERVE : IDLE;
      SERVE: if (tick) begin
        serve_d = serve_q + 16'd1;
        state_d = serve_d == ST ? PLAY : SERVE;
      end
      PLAY: if (tick && miss) begin
        miss_d = 1'b1;
        lives_d = lives_q - 4'd1;
        state_d = lives_q == 4'd1 ? OVER : SERVE;
      end else if (tick) begin
        dx_d = dx_n;
        dy_d = dy_n;
        x_d = dx_n ? x_q + 10'd1 : x_q - 10'd1;
        y_d = dy_n ? y_q + 10'd1 : y_q - 10'd1;
        hit_d = phit;
        score_d = phit && !(&score_q) ? score_q + 1'b1 : score_q;
      end
      OVER: if (rise) begin
        score_d = '0;
        lives_d = LV;
        state_d = SERVE;
      end
    endcase
    if (state_d == SERVE) begin
      x_d = CX;
      y_d = CY;
      dx_d = 1'b1;
      dy_d = 1'b0;
      serve_d = state_q != SERVE ? 16'd0 : serve_d;
    end
  end
  always_ff @(posedge CLK_50)
    if (RESET) begin
      state_q <= IDLE;
      x_q <= CX;
      y_q <= CY;
      dx_q <= 1'b1;
      dy_q <= 1'b0;
      score_q <= '0;
      lives_q <= LV;
      cnt_q <= '0;
      serve_q <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q <= cnt_d;
      serve_q <= serve_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      start_q <= bus.START;
    end
  assign bus.BALL_X = x_q;
  assign bus.BALL_Y = y_q;
  assign bus.SCORE = score_q;
  assign bus.LIVES_LEFT = lives_q;
  assign bus.STATE = state_q;
  assign bus.HIT_PULSE = hit_q;
  assign bus.MISS_PULSE = miss_q;
endmodule

// File: doc/pong_game_core.md
# pong_game_core

Parametrised game engine for the Pong display path. It owns ball motion, wall and paddle collision for up to NUM_PADDLES paddles sharing one row, score, lives, a serve/play/game-over state machine, and a ball-speed divider that shortens as the score rises. It consumes paddle positions from the paddle movers and drives ball coordinates to the box renderer and score to the hex display.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BORDER, 5, wall thickness on the left, right and top walls
- BALL_SIZE, 15, ball edge length
- PADDLE_W, 80, paddle width
- PADDLE_Y, 450, top row of every paddle
- NUM_PADDLES, 2, number of paddles on the paddle row (1..4)
- LIVES, 3, lives per game (1..15)
- SERVE_TICKS, 64, step ticks the ball is held at centre before play
- BASE_DIV, 80000, CLK_50 cycles per step tick at score 0
- DIV_STEP, 500, divider reduction per score point
- MIN_DIV, 20000, divider floor (≥2)
- SCORE_W, 8, score width

- CLK_50  in  1  system clock; all logic runs on its rising edge
- RESET  in  1  synchronous, active-high
- START  in  1  start/restart request, level; the block uses its rising edge internally
- PADDLE_X  in  10*NUM_PADDLES  left x of each paddle; paddle i is in bits [10i+9:10i]
- BALL_X  out  10  ball left x
- BALL_Y  out  10  ball top y
- SCORE  out  SCORE_W  paddle hits this game, saturating
- LIVES_LEFT  out  4  remaining lives
- STATE  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=OVER
- HIT_PULSE  out  1  one-cycle pulse on a paddle hit
- MISS_PULSE  out  1  one-cycle pulse on a ball lost

## Operation
- Reset values: STATE=IDLE; BALL_X=CX=(SCREEN_W-BALL_SIZE)/2 (312); BALL_Y=CY=(SCREEN_H-BALL_SIZE)/2 (232); SCORE=0; LIVES_LEFT=LIVES; pulses=0; dx=+1; dy=-1; step counter=0; START edge register=0.
- Step divider:
  - div = BASE_DIV - DIV_STEP*SCORE, computed 32-bit. div = MIN_DIV when the product exceeds BASE_DIV-MIN_DIV.
  - The counter counts in SERVE/PLAY and is held at 0 in IDLE/OVER.
  - Tick fires when counter ≥ div-1, then the counter clears. The ≥ comparison ensures a shrinking div never causes a wrap.
- IDLE: ball held at centre. A START rising edge moves to SERVE.
- SERVE:
  - Ball held at (CX,CY), dx=+1, dy=-1.
  - After SERVE_TICKS ticks, go to PLAY. The serve tick counter clears on SERVE entry.
- PLAY, on each tick: decide direction from the current position first, then move by (dx,dy) with the new direction.
  - Left wall: BALL_X ≤ BORDER → dx=+1.
  - Right wall: BALL_X+BALL_SIZE ≥ SCREEN_W-BORDER → dx=-1.
  - Top wall: BALL_Y ≤ BORDER → dy=+1.
  - Paddle hit, requires all of:
    - dy=+1;
    - BALL_Y+BALL_SIZE == PADDLE_Y;
    - for some i, BALL_X+BALL_SIZE > PADDLE_X[i] and BALL_X < PADDLE_X[i]+PADDLE_W.
  - On a paddle hit: dy=-1, SCORE+1 (holds at 2^SCORE_W-1), HIT_PULSE=1. A hit on several paddles at once counts as one hit.
  - Wall and paddle reflections on the same tick apply independently (corners flip both axes).
  - Miss: BALL_Y+BALL_SIZE ≥ SCREEN_H on a tick → no move, LIVES_LEFT-1, MISS_PULSE=1. Go to OVER if the result is 0, otherwise SERVE (ball re-centred).
- OVER:
  - Ball frozen at the miss position; SCORE and LIVES_LEFT (0) held.
  - A START rising edge sets SCORE=0 and LIVES_LEFT=LIVES, then goes to SERVE.
- A START edge in SERVE or PLAY is ignored.
- All arithmetic is 11-bit unsigned internally; comparisons never wrap.

## Timing
- All outputs are registered. Any change happens at the CLK_50 edge on which the tick is registered, so it is visible on the cycle after the tick condition.
- START edge → STATE changes at the next edge (1-cycle latency after START is sampled high following a low).
- HIT_PULSE and MISS_PULSE are high for exactly one cycle, coincident with the SCORE/LIVES_LEFT update.
- The new div applies from the tick after a score change.
- RESET mid-game returns every output to its reset value at the next edge, overriding ticks and START.

## Test plan
- Reset: RESET high 2 cycles during PLAY → STATE=0, BALL=(312,232), SCORE=0, LIVES_LEFT=3, pulses 0.
- Serve (BASE_DIV=4, SERVE_TICKS=2): START 0→1 → STATE=1 next cycle; STATE=2 after 8 cycles; first move after 4 more cycles to (313,231).
- Corner: ball at (5,5), direction (-1,-1), tick → (6,6), dx=dy=+1.
- Paddle hit via paddle 1 only: PADDLE_X={0,300}, ball (320,435) descending → next (321,434), SCORE=1, one HIT_PULSE, tick period becomes BASE_DIV-DIV_STEP.
- Misses: paddles at 0 and 500, ball descending at x=300 → at BALL_Y=465, MISS_PULSE, LIVES_LEFT=2, STATE=1, ball at (312,232). After the third miss STATE=3, ball frozen; a START edge → SCORE=0, LIVES_LEFT=3, STATE=1.
- Saturation: force SCORE=255 (SCORE_W=8), hit → SCORE stays 255, HIT_PULSE still fires, div=MIN_DIV.
